io_handshake_unit: RTL and testbench

- Generates the single-cycle `confirmation` and `continue_button` strobes that release the control core's `enable` during OUTPUT, INPUT and PAUSE instructions.
- Takes raw, asynchronous, active-low board push-buttons and synchronises and debounces them.
- Arms only while the control core asserts `is_input`/`is_output`, and emits exactly one strobe per physical press, so each press advances exactly one I/O instruction.
- Sits between the board keys and the control core; its outputs feed the core's `confirmation` and `continue_button` inputs directly.

---
 rtl/io_handshake_unit.sv | 121 ++++++++++++
 tb/tb_io_handshake_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_unit.sv
// Board push-button front end for the control core: synchronises and debounces the
// confirm/continue keys and turns each physical press into one strobe for an I/O instruction.
module io_handshake_unit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_confirm_n,
  input  logic key_continue_n,
  input  logic is_input,
  input  logic is_output,
  output logic confirmation,
  output logic continue_button,
  output logic waiting
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Index 0 is the confirm key, index 1 the continue key; levels are active-low.
  logic [1:0]       sync1_q, sync2_q, lvl_q;
  logic [1:0]       sync1_d, sync2_d, lvl_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   kind_q, kind_d;          // 1 = PAUSE (continue key), 0 = CONFIRM (confirm key)
  logic   confirmation_q, confirmation_d;
  logic   continue_q, continue_d;

  logic req, req_pause, sel_now, sel_kept;

  always_comb begin
    sync1_d = {key_continue_n, key_confirm_n};
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != lvl_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          lvl_d[k] = sync2_q[k];
        end else if (cnt_q[k] != CNT_MAX) begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    req       = is_input | is_output;
    req_pause = is_input & is_output;
    sel_now   = req_pause ? lvl_q[1] : lvl_q[0];
    sel_kept  = kind_q ? lvl_q[1] : lvl_q[0];
    case (state_q)
      S_IDLE: begin
        if (req) begin
          kind_d  = req_pause;
          // A key already down from an earlier instruction must be released first.
          state_d = sel_now ? S_ARMED : S_HOLD;
        end
      end
      S_ARMED: begin
        if (!req || (req_pause != kind_q)) begin
          state_d = S_IDLE;
        end else if (!sel_kept) begin
          state_d = S_FIRE;
        end
      end
      S_FIRE: state_d = S_HOLD;
      S_HOLD: begin
        if (sel_kept) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    confirmation_d = (state_d == S_FIRE) && !kind_d;
    continue_d     = (state_d == S_FIRE) && kind_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q        <= 2'b11;
      sync2_q        <= 2'b11;
      lvl_q          <= 2'b11;
      cnt_q[0]       <= '0;
      cnt_q[1]       <= '0;
      state_q        <= S_IDLE;
      kind_q         <= 1'b0;
      confirmation_q <= 1'b0;
      continue_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      lvl_q          <= lvl_d;
      cnt_q[0]       <= cnt_d[0];
      cnt_q[1]       <= cnt_d[1];
      state_q        <= state_d;
      kind_q         <= kind_d;
      confirmation_q <= confirmation_d;
      continue_q     <= continue_d;
    end
  end

  assign confirmation    = confirmation_q;
  assign continue_button = continue_q;
  assign waiting         = (state_q == S_ARMED);

endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for io_handshake_unit: directed press scenarios plus random key/request traffic,
// every cycle compared against a behavioural press/arm model.
module tb_io_handshake_unit;

  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic key_confirm_n, key_continue_n, is_input, is_output;
  logic confirmation, continue_button, waiting;

  always #5 clock = ~clock;

  io_handshake_unit #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .key_confirm_n  (key_confirm_n),
    .key_continue_n (key_continue_n),
    .is_input       (is_input),
    .is_output      (is_output),
    .confirmation   (confirmation),
    .continue_button(continue_button),
    .waiting        (waiting)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int conf_cnt = 0;
  int cont_cnt = 0;
  logic [2:0] exp_q[$];   // expected {confirmation, continue_button, waiting} per cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys: raw sample history gives the synchronised value two edges late; a level flips
  // after DB consecutive synchronised samples that disagree with it.
  bit m_hist1[2], m_hist2[2], m_lvl[2];
  int m_run[2];
  bit m_armed, m_holding, m_firing, m_kind;

  function automatic bit key_lvl(input bit pause);
    return pause ? m_lvl[1] : m_lvl[0];
  endfunction

  always @(posedge clock or negedge reset) begin
    bit req, pause, raw[2];
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_hist1[k] = 1; m_hist2[k] = 1; m_lvl[k] = 1; m_run[k] = 0;
      end
      m_armed = 0; m_holding = 0; m_firing = 0; m_kind = 0;
    end else begin
      req   = is_input || is_output;
      pause = is_input && is_output;
      if (m_firing) begin
        m_firing  = 0;
        m_holding = 1;
      end else if (m_holding) begin
        if (key_lvl(m_kind)) m_holding = 0;
      end else if (m_armed) begin
        if (!req || pause != m_kind) m_armed = 0;
        else if (!key_lvl(m_kind)) begin
          m_armed  = 0;
          m_firing = 1;
        end
      end else if (req) begin
        m_kind = pause;
        if (key_lvl(pause)) m_armed = 1;
        else m_holding = 1;
      end
      raw[0] = key_confirm_n;
      raw[1] = key_continue_n;
      for (int k = 0; k < 2; k++) begin
        if (m_hist2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_lvl[k] = m_hist2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        m_hist2[k] = m_hist1[k];
        m_hist1[k] = raw[k];
      end
    end
    exp_q.push_back({m_firing && !m_kind, m_firing && m_kind, m_armed});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [2:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 32'd0, 32'd1);
      e = 3'b000;
    end else begin
      e = exp_q.pop_front();
      exp_q.delete();
    end
    check("confirmation", confirmation, e[2]);
    check("continue_button", continue_button, e[1]);
    check("waiting", waiting, e[0]);
    conf_cnt += int'(confirmation);
    cont_cnt += int'(continue_button);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_all(input int n);
    is_input = 0; is_output = 0; key_confirm_n = 1; key_continue_n = 1;
    ticks(n);
    conf_cnt = 0; cont_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard, ra, rb;
    reset = 1; key_confirm_n = 1; key_continue_n = 1; is_input = 0; is_output = 0;
    #2;
    reset = 0; key_confirm_n = 0;
    #1;
    check("rst_conf", confirmation, 0);
    check("rst_cont", continue_button, 0);
    check("rst_wait", waiting, 0);
    ticks(3);
    reset = 1;
    idle_all(8);

    // Confirm press on an OUTPUT instruction, latency 7 after the press edge.
    is_output = 1;
    ticks(2);
    check("wait_before_press", waiting, 1);
    key_confirm_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("conf_latency7", confirmation, 1);
    end
    check("conf_once", conf_cnt, 1);
    check("conf_no_cont", cont_cnt, 0);
    idle_all(10);

    // Debounce: a 3-cycle glitch is ignored, a 5-cycle press fires once.
    is_input = 1;
    ticks(2);
    key_confirm_n = 0; ticks(3); key_confirm_n = 1; ticks(8);
    check("glitch_no_strobe", conf_cnt, 0);
    key_confirm_n = 0; ticks(5); key_confirm_n = 1; ticks(10);
    check("debounced_press", conf_cnt, 1);
    idle_all(10);

    // Pause: confirm key is ignored, continue key fires continue_button.
    is_input = 1; is_output = 1;
    key_confirm_n = 0; ticks(10);
    check("pause_ignores_conf", conf_cnt + cont_cnt, 0);
    check("pause_waiting", waiting, 1);
    key_confirm_n = 1; ticks(8);
    key_continue_n = 0; ticks(10);
    check("pause_cont_once", cont_cnt, 1);
    check("pause_no_conf", conf_cnt, 0);
    idle_all(10);

    // Held key across two OUTPUT instructions gives one strobe; re-press gives another.
    is_output = 1; key_confirm_n = 0;
    for (int i = 0; i < 50; i++) begin
      is_output = (i == 20 || i == 21) ? 0 : 1;
      tick();
    end
    check("held_one_strobe", conf_cnt, 1);
    key_confirm_n = 1; ticks(8);
    key_confirm_n = 0; ticks(10);
    check("repress_second", conf_cnt, 2);
    idle_all(10);

    // Abort: request dropped while armed, later press with no request.
    is_output = 1; ticks(2);
    check("abort_armed", waiting, 1);
    is_output = 0; tick();
    check("abort_wait_low", waiting, 0);
    key_confirm_n = 0; ticks(10);
    check("abort_no_strobe", conf_cnt, 0);
    idle_all(10);

    // Reset mid-strobe, then a held key blocks re-arming.
    is_output = 1; ticks(2);
    key_confirm_n = 0;
    guard = 0;
    while (confirmation !== 1'b1 && guard < 20) begin
      tick(); guard++;
    end
    check("strobe_seen_before_reset", guard < 20, 1);
    reset = 0; is_output = 0;
    #1;
    check("midstrobe_rst_conf", confirmation, 0);
    check("midstrobe_rst_wait", waiting, 0);
    ticks(2);
    reset = 1; conf_cnt = 0;
    ticks(10);
    is_output = 1; ticks(10);
    check("held_after_reset_blocks", conf_cnt, 0);
    check("held_after_reset_nowait", waiting, 0);
    idle_all(10);

    // Random traffic against the model.
    ra = 0; rb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        is_input  = $urandom_range(0, 1);
        is_output = $urandom_range(0, 1);
      end
      if (ra == 0) begin key_confirm_n = ~key_confirm_n; ra = $urandom_range(1, 12); end
      else ra--;
      if (rb == 0) begin key_continue_n = ~key_continue_n; rb = $urandom_range(1, 12); end
      else rb--;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
